// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the I/D memory port arbiter: FSM encodings, byte-enable
// patterns and the memory opcodes seen on opcodeM.
package mem_port_arbiter_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ISSUE_I = 3'd1;
  localparam logic [2:0] ST_ISSUE_D = 3'd2;
  localparam logic [2:0] ST_WAIT_I  = 3'd3;
  localparam logic [2:0] ST_WAIT_D  = 3'd4;

  // Big-endian lanes: bit 3 enables bits 31:24.
  localparam logic [3:0] BE_NONE  = 4'b0000;
  localparam logic [3:0] BE_SB0   = 4'b1000;
  localparam logic [3:0] BE_SH_HI = 4'b1100;
  localparam logic [3:0] BE_SH_LO = 4'b0011;
  localparam logic [3:0] BE_WORD  = 4'b1111;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  function automatic logic [3:0] sb_be(input logic [1:0] off);
    return BE_SB0 >> off;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch port, data port and shared memory port of the arbiter.
// slave = arbiter view; master = requesters plus memory (bench side).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              IReq;
  logic [ADDR_W-1:0] IAddr;
  logic [DATA_W-1:0] IRdata;
  logic              IValid;
  logic              IStall;

  logic              DReq;
  logic              DWe;
  logic [ADDR_W-1:0] DAddr;
  logic [DATA_W-1:0] DWdata;
  logic [5:0]        opcodeM;
  logic [DATA_W-1:0] DRdata;
  logic              DValid;
  logic              DStall;

  logic              MemReq;
  logic              MemReady;
  logic [ADDR_W-3:0] MemAddr;
  logic [3:0]        MemWe;
  logic [DATA_W-1:0] MemWdata;
  logic              MemRvalid;
  logic [DATA_W-1:0] MemRdata;

  modport slave (
    input  IReq, IAddr, DReq, DWe, DAddr, DWdata, opcodeM,
    input  MemReady, MemRvalid, MemRdata,
    output IRdata, IValid, IStall, DRdata, DValid, DStall,
    output MemReq, MemAddr, MemWe, MemWdata
  );

  modport master (
    output IReq, IAddr, DReq, DWe, DAddr, DWdata, opcodeM,
    output MemReady, MemRvalid, MemRdata,
    input  IRdata, IValid, IStall, DRdata, DValid, DStall,
    input  MemReq, MemAddr, MemWe, MemWdata
  );
endinterface

// File: rtl/mem_port_arbiter_store_lane_gen.sv
// Combinational store lane generator: opcode + byte offset -> big-endian byte
// enables and lane-replicated write data; loads yield no enables.
module mem_port_arbiter_store_lane_gen
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        opcode,
  input  logic [1:0]        off,
  input  logic              dwe,
  input  logic [DATA_W-1:0] dwdata,
  output logic [3:0]        we,
  output logic [DATA_W-1:0] wdata
);

  always_comb begin
    we    = BE_NONE;
    wdata = dwdata;
    if (dwe) begin
      case (opcode)
        OP_SB: begin
          we    = sb_be(off);
          wdata = {4{dwdata[7:0]}};
        end
        OP_SH: begin
          we    = off[1] ? BE_SH_LO : BE_SH_HI;
          wdata = {2{dwdata[15:0]}};
        end
        OP_SW:   we = BE_WORD;
        default: we = BE_NONE;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch (I) and load/store (D),
// with D priority except right after a D grant while I waits; stalls until done.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  mem_port_arbiter_if.slave bus
);

  logic [2:0]        state;
  logic              last_d;
  logic              cur_store;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] i_rdata;
  logic [DATA_W-1:0] d_rdata;
  logic              i_valid;
  logic              d_valid;
  logic [3:0]        lane_we;
  logic [DATA_W-1:0] lane_wdata;
  logic              grant_d;
  logic              grant_i;
  logic              unused_iaddr_lsb;

  assign unused_iaddr_lsb = ^bus.IAddr[1:0];

  mem_port_arbiter_store_lane_gen #(.DATA_W(DATA_W)) u_store_lane_gen (
    .opcode (bus.opcodeM),
    .off    (bus.DAddr[1:0]),
    .dwe    (bus.DWe),
    .dwdata (bus.DWdata),
    .we     (lane_we),
    .wdata  (lane_wdata)
  );

  // I only wins when the previous grant went to D and I is waiting.
  assign grant_d = bus.DReq & ~(last_d & bus.IReq);
  assign grant_i = bus.IReq & ~grant_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_d    <= 1'b0;
      cur_store <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= BE_NONE;
      mem_wdata <= '0;
      i_rdata   <= '0;
      d_rdata   <= '0;
      i_valid   <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_d) begin
            state     <= ST_ISSUE_D;
            last_d    <= 1'b1;
            cur_store <= bus.DWe;
            mem_addr  <= bus.DAddr[ADDR_W-1:2];
            mem_we    <= lane_we;
            mem_wdata <= lane_wdata;
          end else if (grant_i) begin
            state     <= ST_ISSUE_I;
            last_d    <= 1'b0;
            cur_store <= 1'b0;
            mem_addr  <= bus.IAddr[ADDR_W-1:2];
            mem_we    <= BE_NONE;
            mem_wdata <= '0;
          end
        end
        ST_ISSUE_I: if (bus.MemReady) state <= ST_WAIT_I;
        ST_ISSUE_D: begin
          // Stores get no memory response, so they complete on accept.
          if (bus.MemReady) begin
            if (cur_store) begin
              state   <= ST_IDLE;
              d_valid <= 1'b1;
            end else begin
              state <= ST_WAIT_D;
            end
          end
        end
        ST_WAIT_I: begin
          if (bus.MemRvalid) begin
            i_rdata <= bus.MemRdata;
            i_valid <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_WAIT_D: begin
          if (bus.MemRvalid) begin
            d_rdata <= bus.MemRdata;
            d_valid <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.MemReq   = (state == ST_ISSUE_I) || (state == ST_ISSUE_D);
  assign bus.MemAddr  = mem_addr;
  assign bus.MemWe    = mem_we;
  assign bus.MemWdata = mem_wdata;
  assign bus.IRdata   = i_rdata;
  assign bus.IValid   = i_valid;
  assign bus.IStall   = bus.IReq & ~i_valid;
  assign bus.DRdata   = d_rdata;
  assign bus.DValid   = d_valid;
  assign bus.DStall   = bus.DReq & ~d_valid;

endmodule
